xdma_burst_receiver: RTL

Destination-side counterpart of the xDMA write-burst path. Accepts one AXI-style write burst at a time (AW descriptor, then W beats) on the cluster's inbound port. Forwards each beat to a local memory write port and returns a single B response per burst. Pulses a one-cycle completion strobe towards the local xDMA frontend once the response handshake completes.

---
 rtl/xdma_burst_receiver.sv | 123 ++++++++++++
 1 files changed

// File: rtl/xdma_burst_receiver.sv
// Destination side of the xDMA write-burst path: takes one AW + W burst, writes each
// beat straight through to local memory, answers with a single B and a done strobe.
module xdma_burst_receiver #(
    parameter int AddrWidth = 48,
    parameter int DataWidth = 512,
    parameter int LenWidth  = 8,
    parameter int IdWidth   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [LenWidth-1:0]    aw_len_i,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_last_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [IdWidth-1:0]     b_id_o,
    output logic [1:0]             b_resp_o,
    output logic                   mem_req_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_data_o,
    output logic [DataWidth/8-1:0] mem_strb_o,
    input  logic                   mem_gnt_i,
    output logic                   write_req_done_o,
    output logic [LenWidth:0]      beats_o
);

    localparam logic [AddrWidth-1:0] BeatBytes = AddrWidth'(DataWidth / 8);
    localparam logic [AddrWidth-1:0] AlignMask = ~(BeatBytes - AddrWidth'(1));

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t               state, state_n;
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  len;
    logic [LenWidth-1:0]  beat_cnt;
    logic [IdWidth-1:0]   id;
    logic                 err;
    logic                 done;
    logic [LenWidth:0]    beats;
    logic                 aw_fire, w_fire, b_fire, last_beat;

    assign aw_fire   = aw_valid_i & aw_ready_o;
    assign w_fire    = w_valid_i & w_ready_o;
    assign b_fire    = b_valid_o & b_ready_i;
    assign last_beat = (beat_cnt == len);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // Handshake outputs are forced low while reset is asserted so the reset
    // cycle itself looks idle to both neighbours.
    always_comb begin
        state_n    = state;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        mem_req_o  = 1'b0;
        b_valid_o  = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    aw_ready_o = 1'b1;
                    if (aw_valid_i) state_n = DATA;
                end
                DATA: begin
                    w_ready_o = mem_gnt_i;
                    mem_req_o = w_valid_i;
                    if (w_fire && last_beat) state_n = RESP;
                end
                RESP: begin
                    b_valid_o = 1'b1;
                    if (b_ready_i) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign mem_addr_o       = addr;
    assign mem_data_o       = w_data_i;
    assign mem_strb_o       = w_strb_i;
    assign b_id_o           = id;
    assign b_resp_o         = err ? 2'b10 : 2'b00;
    assign write_req_done_o = done & ~rst_i;
    assign beats_o          = rst_i ? '0 : beats;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr     <= '0;
            len      <= '0;
            beat_cnt <= '0;
            id       <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
            beats    <= '0;
        end else begin
            done <= b_fire;
            if (aw_fire) begin
                addr     <= aw_addr_i & AlignMask;
                len      <= aw_len_i;
                id       <= aw_id_i;
                beat_cnt <= '0;
                err      <= 1'b0;
            end
            // The burst ends on count alone; a misplaced w_last only flags an error.
            if (w_fire) begin
                addr     <= addr + BeatBytes;
                beat_cnt <= beat_cnt + LenWidth'(1);
                if (w_last_i != last_beat) err <= 1'b1;
            end
            if (b_fire) beats <= {1'b0, len} + (LenWidth + 1)'(1);
        end
    end

endmodule
